gpio_int_det: RTL and testbench

- Input-side stage directly downstream of the GPIO configuration registers.
- Consumes per-pin interrupt configuration (enable, type, polarity, both-edge) and the raw GPIO pins.
- Synchronises the pins, detects level and edge events, and holds sticky per-pin status bits that software clears by writing 1 (W1C pulse from the register decoder).
- Drives one registered interrupt request to the CPU interrupt controller.

---
 rtl/gpio_pkg.sv | 12 +
 rtl/gpio_sync_db.sv | 49 ++++
 rtl/gpio_int_det.sv | 115 +++++++++++
 tb/tb_gpio_int_det.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt detector: config bit meanings
// and the warm-up saturation value.
package gpio_pkg;

  localparam logic INT_LEVEL = 1'b0;
  localparam logic INT_EDGE  = 1'b1;
  localparam logic POL_LOW   = 1'b0;
  localparam logic POL_HIGH  = 1'b1;

  localparam logic [1:0] WARM_MAX = 2'd3;

endpackage

// File: rtl/gpio_sync_db.sv
// Per-pin 2-flop synchroniser with an optional 3-sample debounce history.
// The debounce path is built only when GPIO_DEBOUNCE_EN is defined.
module gpio_sync_db (
  input  logic clk,
  input  logic rst,
  input  logic pin,
`ifdef GPIO_DEBOUNCE_EN
  input  logic tick,
`endif
  output logic sync_val
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [2:0] hist;

  // The filtered value only moves once three consecutive tick samples agree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= 3'b000;
      sync_val <= 1'b0;
    end else begin
      if (tick) begin
        hist <= {hist[1:0], sync2};
      end
      if (&hist) begin
        sync_val <= 1'b1;
      end else if (~|hist) begin
        sync_val <= 1'b0;
      end
    end
  end
`else
  assign sync_val = sync2;
`endif

endmodule

// File: rtl/gpio_int_det.sv
// GPIO interrupt detector: synchronises pins, detects level/edge events,
// keeps W1C sticky status and drives a registered IRQ. Debounce: GPIO_DEBOUNCE_EN.
module gpio_int_det
  import gpio_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DB_DIV = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] gpio_i,
  input  logic [DW-1:0] int_en_i,
  input  logic [DW-1:0] int_type_i,
  input  logic [DW-1:0] int_pol_i,
  input  logic [DW-1:0] int_both_i,
  input  logic [DW-1:0] sts_clr_i,
  output logic [DW-1:0] in_sync_o,
  output logic [DW-1:0] sts_o,
  output logic          irq_o
);

  if (DB_DIV < 2) begin : g_bad_div
    $error("gpio_int_det: DB_DIV must be at least 2");
  end

  logic [DW-1:0] sync_vec;
  logic [DW-1:0] prev;
  logic [DW-1:0] evt;
  logic [1:0]    warm;
  logic          armed;

`ifdef GPIO_DEBOUNCE_EN
  localparam int PW = (DB_DIV > 2) ? $clog2(DB_DIV) : 1;

  logic [PW-1:0] pre;
  logic          tick;
  logic          armed_q;

  assign tick = (pre == PW'(DB_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

  // Filtered pins settle on tick boundaries, so arming waits for one more tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
    end else if ((warm == WARM_MAX) && tick) begin
      armed_q <= 1'b1;
    end
  end

  assign armed = armed_q;
`else
  assign armed = (warm == WARM_MAX);
`endif

  for (genvar i = 0; i < DW; i++) begin : g_pin
    gpio_sync_db u_sync (
      .clk      (clk),
      .rst      (rst),
      .pin      (gpio_i[i]),
`ifdef GPIO_DEBOUNCE_EN
      .tick     (tick),
`endif
      .sync_val (sync_vec[i])
    );
  end

  assign in_sync_o = sync_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm <= 2'd0;
    end else if (warm != WARM_MAX) begin
      warm <= warm + 2'd1;
    end
  end

  always_comb begin
    evt = '0;
    for (int i = 0; i < DW; i++) begin
      logic rise;
      logic fall;
      logic edge_evt;
      logic lvl_evt;
      rise     = in_sync_o[i] & ~prev[i];
      fall     = ~in_sync_o[i] & prev[i];
      edge_evt = int_both_i[i] ? (rise | fall)
                               : ((int_pol_i[i] == POL_HIGH) ? rise : fall);
      lvl_evt  = (int_pol_i[i] == POL_HIGH) ? in_sync_o[i] : ~in_sync_o[i];
      evt[i]   = armed & int_en_i[i] &
                 ((int_type_i[i] == INT_EDGE) ? edge_evt : lvl_evt);
    end
  end

  // A new event wins over a same-cycle clear; irq trails status by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= '0;
      sts_o <= '0;
      irq_o <= 1'b0;
    end else begin
      prev  <= in_sync_o;
      sts_o <= (sts_o & ~sts_clr_i) | evt;
      irq_o <= |(sts_o & int_en_i);
    end
  end

endmodule

// File: tb/tb_gpio_int_det.sv
// Self-checking bench for gpio_int_det (default build, no debounce):
// directed scenarios plus randomized traffic against a delay-line reference model.
module tb_gpio_int_det;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gpio_i;
  logic [7:0] int_en;
  logic [7:0] int_type;
  logic [7:0] int_pol;
  logic [7:0] int_both;
  logic [7:0] sts_clr;
  logic [7:0] in_sync;
  logic [7:0] sts;
  logic       irq;

  int errs   = 0;
  int checks = 0;

  logic [7:0] gh[$];
  logic [7:0] m_sts;
  logic [7:0] m_insync;
  logic       m_irq;

  gpio_int_det #(.DW(8), .DB_DIV(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_i     (gpio_i),
    .int_en_i   (int_en),
    .int_type_i (int_type),
    .int_pol_i  (int_pol),
    .int_both_i (int_both),
    .sts_clr_i  (sts_clr),
    .in_sync_o  (in_sync),
    .sts_o      (sts),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pin value applied before clock edge i (1-based since reset release); 0 before that.
  function automatic logic [7:0] gval(input int i);
    if (i < 1) return 8'h00;
    return gh[i-1];
  endfunction

  // Drive one cycle of pins/clear, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic [7:0] g, input logic [7:0] clr);
    int k;
    logic [7:0] cur;
    logic [7:0] prv;
    logic [7:0] evt;
    gpio_i  = g;
    sts_clr = clr;
    gh.push_back(g);
    k   = gh.size();
    cur = gval(k - 2);
    prv = gval(k - 3);
    evt = 8'h00;
    if (k >= 4) begin
      for (int p = 0; p < 8; p++) begin
        if (int_en[p]) begin
          if (int_type[p]) begin
            if (int_both[p]) evt[p] = (cur[p] != prv[p]);
            else             evt[p] = (cur[p] != prv[p]) && (cur[p] == int_pol[p]);
          end else begin
            evt[p] = (cur[p] == int_pol[p]);
          end
        end
      end
    end
    m_irq    = |(m_sts & int_en);
    m_sts    = (m_sts & ~clr) | evt;
    m_insync = gval(k - 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("sts", sts, m_sts);
    checkOutput("irq", irq, m_irq);
    checkOutput("in_sync", in_sync, m_insync);
  endtask

  task automatic modelReset();
    gh.delete();
    m_sts    = 8'h00;
    m_insync = 8'h00;
    m_irq    = 1'b0;
  endtask

  initial begin
    logic [7:0] g;
    rst      = 1'b0;
    gpio_i   = 8'hFF;
    int_en   = 8'hFF;
    int_type = 8'hFF;
    int_pol  = 8'hFF;
    int_both = 8'h00;
    sts_clr  = 8'h00;
    modelReset();

    // Pins already high at reset must not produce an edge after warm-up.
    repeat (3) @(negedge clk);
    checkOutput("reset_sts", sts, 8'h00);
    checkOutput("reset_irq", irq, 1'b0);
    checkOutput("reset_in_sync", in_sync, 8'h00);
    rst = 1'b1;
    repeat (10) applyStimulus(8'hFF, 8'h00);
    checkOutput("warmup_sts", sts, 8'h00);
    checkOutput("warmup_irq", irq, 1'b0);

    // Pin3 rising edge latency and W1C clear.
    repeat (5) applyStimulus(8'hF7, 8'h00);
    applyStimulus(8'hFF, 8'h00);
    applyStimulus(8'hFF, 8'h00);
    checkOutput("p3_sts_E1", sts, 8'h00);
    applyStimulus(8'hFF, 8'h00);
    checkOutput("p3_sts_E2", sts, 8'h08);
    checkOutput("p3_irq_E2", irq, 1'b0);
    applyStimulus(8'hFF, 8'h00);
    checkOutput("p3_irq_E3", irq, 1'b1);
    applyStimulus(8'hFF, 8'h08);
    checkOutput("p3_clr_sts", sts, 8'h00);
    checkOutput("p3_clr_irq_lag", irq, 1'b1);
    applyStimulus(8'hFF, 8'h00);
    checkOutput("p3_clr_irq", irq, 1'b0);

    // Pin0 level-low: clear is ineffective while active.
    int_en   = 8'h01;
    int_type = 8'hFE;
    int_pol  = 8'hFE;
    repeat (4) applyStimulus(8'hFE, 8'h00);
    applyStimulus(8'hFE, 8'h01);
    checkOutput("p0_lvl_hold", sts[0], 1'b1);
    repeat (3) applyStimulus(8'hFF, 8'h00);
    applyStimulus(8'hFF, 8'h01);
    checkOutput("p0_lvl_clr", sts[0], 1'b0);

    // Pin5 both edges, clear between, clear coincident with the second edge.
    int_en   = 8'h20;
    int_type = 8'hFF;
    int_pol  = 8'hFF;
    int_both = 8'h20;
    repeat (3) applyStimulus(8'hDF, 8'h00);
    checkOutput("p5_fall", sts[5], 1'b1);
    applyStimulus(8'hDF, 8'h20);
    checkOutput("p5_clr", sts[5], 1'b0);
    applyStimulus(8'hFF, 8'h00);
    applyStimulus(8'hFF, 8'h00);
    applyStimulus(8'hFF, 8'h20);
    checkOutput("p5_rise_vs_clr", sts[5], 1'b1);

    // Pin2 masked, then unmasked with existing status.
    int_both = 8'h00;
    int_en   = 8'h00;
    applyStimulus(8'hFF, 8'h20);
    repeat (4) applyStimulus(8'hFB, 8'h00);
    repeat (4) applyStimulus(8'hFF, 8'h00);
    checkOutput("p2_masked_sts", sts[2], 1'b0);
    checkOutput("p2_masked_irq", irq, 1'b0);
    int_en = 8'h04;
    repeat (4) applyStimulus(8'hFB, 8'h00);
    repeat (4) applyStimulus(8'hFF, 8'h00);
    int_en = 8'h00;
    applyStimulus(8'hFF, 8'h00);
    checkOutput("p2_off_irq", irq, 1'b0);
    checkOutput("p2_held_sts", sts[2], 1'b1);
    int_en = 8'h04;
    applyStimulus(8'hFF, 8'h00);
    checkOutput("p2_on_irq", irq, 1'b1);

    // Randomized traffic with sparse pin toggles, clears and config changes.
    g = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        int_en   = 8'($urandom);
        int_type = 8'($urandom);
        int_pol  = 8'($urandom);
        int_both = 8'($urandom);
      end
      g = g ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      applyStimulus(g, 8'($urandom) & 8'($urandom) & 8'($urandom));
    end

    // Make sure something is set, then assert reset mid-cycle.
    int_en   = 8'hFF;
    int_type = 8'h00;
    int_pol  = 8'hFF;
    repeat (4) applyStimulus(8'hFF, 8'h00);
    checkOutput("pre_reset_sts", sts, 8'hFF);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_sts", sts, 8'h00);
    checkOutput("async_rst_irq", irq, 1'b0);
    checkOutput("async_rst_in_sync", in_sync, 8'h00);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) applyStimulus(8'hFF, 8'h00);
    for (int n = 0; n < 40; n++) begin
      g = g ^ (8'($urandom) & 8'($urandom));
      applyStimulus(g, 8'($urandom) & 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
